// File: rtl/multi_pipe_pkg.sv
// rtl/multi_pipe_pkg.sv - shared defaults and channel-id sizing for the multi-pipeline arbiter
package multi_pipe_pkg;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_MAX_OUT = 8;

  // A single channel still needs a one-bit id field on the resource bus.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [id_w(DEF_NUM_CH)-1:0] chan_id_t;

endpackage

// File: rtl/multi_pipeline_arbiter_if.sv
// rtl/multi_pipeline_arbiter_if.sv - producer, resource and consumer signals of the arbiter
interface multi_pipeline_arbiter_if #(
  parameter int NUM_CH = multi_pipe_pkg::DEF_NUM_CH,
  parameter int DATA_W = multi_pipe_pkg::DEF_DATA_W
);
  localparam int ID_W = multi_pipe_pkg::id_w(NUM_CH);

  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        flush;
  logic [NUM_CH-1:0]        out_stall;

  logic                     res_req_valid;
  logic [DATA_W-1:0]        res_req_data;
  logic [ID_W-1:0]          res_req_id;
  logic                     res_rsp_valid;
  logic [DATA_W-1:0]        res_rsp_data;
  logic [ID_W-1:0]          res_rsp_id;

  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_valid;
  logic                     err_orphan;

  modport slave (
    input  in_data, in_valid, flush, res_rsp_valid, res_rsp_data, res_rsp_id,
    output out_stall, res_req_valid, res_req_data, res_req_id, out_data, out_valid, err_orphan
  );

  modport master (
    output in_data, in_valid, flush, res_rsp_valid, res_rsp_data, res_rsp_id,
    input  out_stall, res_req_valid, res_req_data, res_req_id, out_data, out_valid, err_orphan
  );

endinterface

// File: rtl/multi_pipeline_arbiter_chan_fifo.sv
// rtl/multi_pipeline_arbiter_chan_fifo.sv - per-channel input buffer with one-cycle flush
module chan_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_pipeline_arbiter.sv
// rtl/multi_pipeline_arbiter.sv - round-robin sharing of one tagged resource among NUM_CH buffered channels
module multi_pipeline_arbiter
  import multi_pipe_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input  logic clk,
  input  logic reset,
  input  logic global_stall,
  multi_pipeline_arbiter_if.slave bus
);
  localparam int ID_W  = id_w(NUM_CH);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  logic [DATA_W-1:0]        head [NUM_CH];
  logic [NUM_CH-1:0]        full;
  logic [NUM_CH-1:0]        empty;
  logic [NUM_CH-1:0]        push;
  logic [NUM_CH-1:0]        pop;
  logic [NUM_CH-1:0]        fifo_flush;
  logic [NUM_CH-1:0]        eligible;

  logic [CNT_W-1:0]         outstanding [NUM_CH];
  logic [CNT_W-1:0]         drop_cnt    [NUM_CH];
  logic [CNT_W-1:0]         out_nxt     [NUM_CH];
  logic [CNT_W-1:0]         drop_nxt    [NUM_CH];
  logic [NUM_CH-1:0]        rsp_live;
  logic [NUM_CH-1:0]        deliver;
  logic                     rsp_ok;
  logic                     orphan;

  logic [ID_W-1:0]          rr_ptr;
  logic                     grant_valid;
  logic [ID_W-1:0]          grant_id;
  logic [DATA_W-1:0]        grant_data;

  logic                     req_valid_q;
  logic [DATA_W-1:0]        req_data_q;
  logic [ID_W-1:0]          req_id_q;
  logic [NUM_CH-1:0]        out_valid_q;
  logic [NUM_CH*DATA_W-1:0] out_data_q;
  logic                     err_q;

  assign bus.out_stall = {NUM_CH{global_stall}} | full;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign push[c]       = bus.in_valid[c] && !bus.out_stall[c] && !bus.flush[c];
    assign fifo_flush[c] = bus.flush[c] && !global_stall;
    assign eligible[c]   = !empty[c] && (outstanding[c] < MAX_CNT) && !bus.flush[c] && !global_stall;
    assign pop[c]        = grant_valid && (grant_id == ID_W'(c));

    chan_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[c]),
      .pop   (pop[c]),
      .flush (fifo_flush[c]),
      .wdata (bus.in_data[c*DATA_W +: DATA_W]),
      .rdata (head[c]),
      .full  (full[c]),
      .empty (empty[c])
    );
  end

  // First eligible channel at or after rr_ptr wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_id    = '0;
    grant_data  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_CH;
      if (!grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(idx);
        grant_data  = head[idx];
      end
    end
  end

  // A response only counts against a channel that actually has work in flight.
  always_comb begin
    rsp_ok = bus.res_rsp_valid && !global_stall;
    for (int c = 0; c < NUM_CH; c++) begin
      rsp_live[c] = rsp_ok && (bus.res_rsp_id == ID_W'(c)) && (outstanding[c] != '0);
      out_nxt[c]  = outstanding[c] + CNT_W'(pop[c]) - CNT_W'(rsp_live[c]);
      drop_nxt[c] = fifo_flush[c] ? out_nxt[c]
                  : drop_cnt[c] - CNT_W'(rsp_live[c] && (drop_cnt[c] != '0));
      deliver[c]  = rsp_live[c] && (drop_cnt[c] == '0) && !bus.flush[c];
    end
    orphan = rsp_ok && !(|rsp_live);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr      <= '0;
      req_valid_q <= 1'b0;
      req_data_q  <= '0;
      req_id_q    <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        outstanding[c] <= '0;
        drop_cnt[c]    <= '0;
      end
    end else if (!global_stall) begin
      req_valid_q <= grant_valid;
      if (grant_valid) begin
        req_data_q <= grant_data;
        req_id_q   <= grant_id;
        rr_ptr     <= (int'(grant_id) == NUM_CH - 1) ? '0 : grant_id + ID_W'(1);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        outstanding[c] <= out_nxt[c];
        drop_cnt[c]    <= drop_nxt[c];
        out_valid_q[c] <= deliver[c];
        if (deliver[c]) begin
          out_data_q[c*DATA_W +: DATA_W] <= bus.res_rsp_data;
        end
      end
      if (orphan) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.res_req_valid = req_valid_q;
  assign bus.res_req_data  = req_data_q;
  assign bus.res_req_id    = req_id_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.err_orphan    = err_q;

endmodule

// File: tb/tb_multi_pipeline_arbiter.sv
// tb/tb_multi_pipeline_arbiter.sv - directed scoreboard bench for multi_pipeline_arbiter
module tb_multi_pipeline_arbiter;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  logic global_stall;

  int n_pass  = 0;
  int n_total = 0;

  logic [33:0] req_q [$];
  logic [33:0] out_q [$];

  multi_pipeline_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  multi_pipeline_arbiter #(
    .NUM_CH  (NUM_CH),
    .DATA_W  (DATA_W),
    .DEPTH   (4),
    .MAX_OUT (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .global_stall (global_stall),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void exp_req(input int id, input logic [31:0] d);
    req_q.push_back({2'(id), d});
  endfunction

  function automatic void exp_out(input int id, input logic [31:0] d);
    out_q.push_back({2'(id), d});
  endfunction

  task automatic push1(input int c, input logic [31:0] d);
    bus.in_valid[c] = 1'b1;
    bus.in_data[c*DATA_W +: DATA_W] = d;
    tick(1);
    bus.in_valid = '0;
  endtask

  task automatic rsp(input int id, input logic [31:0] d, input bit deliver);
    bus.res_rsp_valid = 1'b1;
    bus.res_rsp_id    = 2'(id);
    bus.res_rsp_data  = d;
    if (deliver) exp_out(id, d);
    tick(1);
    bus.res_rsp_valid = 1'b0;
  endtask

  // Monitor: every presented output must match the head of its scoreboard queue.
  initial begin : monitor
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.res_req_valid) begin
          if (req_q.size() == 0) begin
            n_total++;
            $display("FAIL req_unexpected: got id %0d data %h, required no request",
                     bus.res_req_id, bus.res_req_data);
          end else begin
            e = req_q.pop_front();
            check("res_req", {30'd0, bus.res_req_id, bus.res_req_data}, {30'd0, e});
          end
        end
        for (int c = 0; c < NUM_CH; c++) begin
          if (bus.out_valid[c]) begin
            if (out_q.size() == 0) begin
              n_total++;
              $display("FAIL out_unexpected: got ch %0d data %h, required no output",
                       c, bus.out_data[c*DATA_W +: DATA_W]);
            end else begin
              e = out_q.pop_front();
              check("out", {30'd0, 2'(c), bus.out_data[c*DATA_W +: DATA_W]}, {30'd0, e});
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin : stimulus
    reset             = 1'b0;
    global_stall      = 1'b0;
    bus.in_valid      = '0;
    bus.in_data       = '0;
    bus.flush         = '0;
    bus.res_rsp_valid = 1'b0;
    bus.res_rsp_id    = '0;
    bus.res_rsp_data  = '0;

    // Reset state
    tick(2);
    @(negedge clk);
    check("rst_req_valid", 64'(bus.res_req_valid), 64'd0);
    check("rst_req_data",  64'(bus.res_req_data),  64'd0);
    check("rst_out_valid", 64'(bus.out_valid),     64'd0);
    check("rst_out_data",  64'(bus.out_data[63:0]), 64'd0);
    check("rst_err",       64'(bus.err_orphan),    64'd0);
    check("rst_out_stall", 64'(bus.out_stall),     64'd0);
    global_stall = 1'b1;
    #1;
    check("rst_out_stall_gs", 64'(bus.out_stall), 64'hF);
    global_stall = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);

    // Single push latency and delivery
    bus.in_valid[0] = 1'b1;
    bus.in_data[31:0] = 32'hA5;
    exp_req(0, 32'hA5);
    tick(1);
    bus.in_valid = '0;
    @(negedge clk);
    check("lat_t1", 64'(bus.res_req_valid), 64'd0);
    tick(1);
    @(negedge clk);
    check("lat_t2", 64'(bus.res_req_valid), 64'd1);
    tick(2);
    rsp(0, 32'hA6, 1'b1);
    tick(3);

    // All channels push each cycle; fresh reset so rr_ptr starts at 0
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < NUM_CH; c++)
        exp_req(c, 32'hC000_0000 | (c << 8) | k);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < NUM_CH; c++)
        bus.in_data[c*DATA_W +: DATA_W] = 32'hC000_0000 | (c << 8) | k;
      bus.in_valid = 4'hF;
      if (k == 3) begin
        @(negedge clk);
        check("rr_stall_pre", 64'(bus.out_stall), 64'h0);
      end
      tick(1);
    end
    bus.in_valid = '0;
    @(negedge clk);
    check("rr_stall_full", 64'(bus.out_stall), 64'h8);
    tick(16);
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < NUM_CH; c++)
        rsp(c, 32'hD000_0000 | (c << 8) | k, 1'b1);
    tick(2);

    // Flush ch1 with 3 outstanding; ch2 keeps working
    for (int k = 0; k < 3; k++) begin
      exp_req(1, 32'h1100 + k);
      push1(1, 32'h1100 + k);
    end
    tick(4);
    exp_req(2, 32'h2200);
    push1(2, 32'h2200);
    tick(4);
    bus.flush[1] = 1'b1;
    tick(1);
    bus.flush = '0;
    exp_req(1, 32'h1104);
    push1(1, 32'h1104);
    tick(4);
    rsp(1, 32'hF001, 1'b0);
    rsp(1, 32'hF002, 1'b0);
    rsp(2, 32'hF022, 1'b1);
    rsp(1, 32'hF003, 1'b0);
    rsp(1, 32'hF004, 1'b1);
    tick(2);
    @(negedge clk);
    check("flush_no_err", 64'(bus.err_orphan), 64'd0);

    // Global stall with a pending response and push
    exp_req(0, 32'h0E0E);
    push1(0, 32'h0E0E);
    tick(4);
    global_stall      = 1'b1;
    bus.res_rsp_valid = 1'b1;
    bus.res_rsp_id    = 2'd0;
    bus.res_rsp_data  = 32'h0F0F;
    bus.in_valid[3]   = 1'b1;
    bus.in_data[3*DATA_W +: DATA_W] = 32'h3333;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_stall", 64'(bus.out_stall), 64'hF);
      tick(1);
    end
    global_stall = 1'b0;
    exp_out(0, 32'h0F0F);
    exp_req(3, 32'h3333);
    tick(1);
    bus.res_rsp_valid = 1'b0;
    bus.in_valid      = '0;
    tick(4);
    rsp(3, 32'h3434, 1'b1);
    tick(2);

    // Orphan response on ch3
    @(negedge clk);
    check("orphan_pre", 64'(bus.err_orphan), 64'd0);
    tick(1);
    rsp(3, 32'hBAD0, 1'b0);
    @(negedge clk);
    check("orphan_set", 64'(bus.err_orphan), 64'd1);
    tick(5);
    @(negedge clk);
    check("orphan_sticky", 64'(bus.err_orphan), 64'd1);
    tick(1);

    // Saturate ch0: 8 outstanding plus a full buffer, then reset mid-flight
    for (int k = 0; k < 12; k++) begin
      if (k < 8) exp_req(0, 32'hE000_0000 + k);
      bus.in_valid[0] = 1'b1;
      bus.in_data[31:0] = 32'hE000_0000 + k;
      tick(1);
    end
    bus.in_valid = '0;
    @(negedge clk);
    check("sat_full", 64'(bus.out_stall), 64'h1);
    tick(3);
    @(negedge clk);
    check("sat_no_req", 64'(bus.res_req_valid), 64'd0);
    reset             = 1'b0;
    bus.res_rsp_valid = 1'b1;
    bus.res_rsp_id    = 2'd0;
    bus.res_rsp_data  = 32'h5555;
    tick(1);
    bus.res_rsp_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_req_valid", 64'(bus.res_req_valid), 64'd0);
    check("mid_rst_req_data",  64'(bus.res_req_data),  64'd0);
    check("mid_rst_req_id",    64'(bus.res_req_id),    64'd0);
    check("mid_rst_out_valid", 64'(bus.out_valid),     64'd0);
    check("mid_rst_out_data",  64'(bus.out_data[63:0]), 64'd0);
    check("mid_rst_err",       64'(bus.err_orphan),    64'd0);
    check("mid_rst_out_stall", 64'(bus.out_stall),     64'd0);
    reset = 1'b1;
    tick(1);
    exp_req(0, 32'h7777);
    push1(0, 32'h7777);
    tick(4);
    rsp(0, 32'h7878, 1'b1);

    for (int i = 0; i < 50 && (req_q.size() != 0 || out_q.size() != 0); i++) tick(1);
    check("req_q_drained", 64'(req_q.size()), 64'd0);
    check("out_q_drained", 64'(out_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multi_pipeline_arbiter.md
MULTI_PIPELINE_ARBITER -- requirements
Module: multi_pipeline_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, is the number of producer/consumer channels sharing one resource (2..8).
REQ-002 Parameter DATA_W, default 32, is the data width of every channel and the resource.
REQ-003 Parameter DEPTH, default 4, is the per-channel input buffer depth (power of two, at least 2).
REQ-004 Parameter MAX_OUT, default 8, is the maximum outstanding resource requests per channel.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 global_stall  input  1  freezes all state when high.
REQ-008 in_data  input  NUM_CH*DATA_W  producer data; channel c occupies bits [c*DATA_W +: DATA_W].
REQ-009 in_valid  input  NUM_CH  per-channel producer valid.
REQ-010 flush  input  NUM_CH  per-channel flush request.
REQ-011 out_stall  output  NUM_CH  per-channel backpressure to the producer.
REQ-012 res_req_valid / res_req_data / res_req_id  output  1 / DATA_W / clog2(NUM_CH)  registered request to the shared resource.
REQ-013 res_rsp_valid / res_rsp_data / res_rsp_id  input  1 / DATA_W / clog2(NUM_CH)  resource response, tagged with the channel id.
REQ-014 out_data / out_valid  output  NUM_CH*DATA_W / NUM_CH  registered per-channel result to the consumer.
REQ-015 err_orphan  output  1  sticky flag: a response arrived for a channel with no outstanding request.

Function
REQ-016 global_stall=1 SHALL hold every register, block all pushes and grants, and cause res_rsp_valid to be ignored; the resource shares global_stall and holds its response.
REQ-017 out_stall[c] SHALL equal global_stall OR buffer c full.
REQ-018 A push into buffer c SHALL occur when in_valid[c] is high, out_stall[c] is low and flush[c] is low.
REQ-019 Channel c SHALL be eligible for arbitration when buffer c is non-empty, outstanding[c] < MAX_OUT and flush[c] is low.
REQ-020 Arbitration SHALL be round-robin, with at most one grant per cycle.
REQ-021 The search SHALL start at rr_ptr, and rr_ptr SHALL become (granted+1) mod NUM_CH after a grant and stay unchanged otherwise.
REQ-022 A grant in cycle t SHALL pop the head of that buffer and drive res_req_valid=1 with that data and id in cycle t+1.
REQ-023 res_req_valid SHALL be 0 in any cycle that follows a cycle without a grant.
REQ-024 Latency from a push into an empty buffer (cycle t) to the matching res_req_valid SHALL be 2 cycles, provided there is no contention.
REQ-025 outstanding[c] SHALL increment on a grant to c and decrement on an accepted response for c.
REQ-026 When a grant to c and an accepted response for c occur in the same cycle, outstanding[c] SHALL be unchanged.
REQ-027 A response for channel c with drop_cnt[c]=0 SHALL produce out_valid[c]=1 and out_data[c]=res_rsp_data in the next cycle; out_valid is otherwise 0.
REQ-028 flush[c] SHALL empty buffer c in one cycle.
REQ-029 flush[c] SHALL set drop_cnt[c] to the next-cycle value of outstanding[c].
REQ-030 flush[c] SHALL suppress any out_valid[c] generated in the same cycle.
REQ-031 A response for c with drop_cnt[c]>0 SHALL be discarded, and both drop_cnt[c] and outstanding[c] SHALL decrement.
REQ-032 A response whose id has outstanding=0 SHALL set err_orphan, SHALL be discarded, and SHALL leave the counters unchanged.
REQ-033 Flush on one channel SHALL NOT affect any other channel's buffer, counters or outputs.

Reset
REQ-034 While reset=0 at a clock edge, the block SHALL clear: all buffers to empty, all counters, rr_ptr, res_req_valid, out_valid and err_orphan.
REQ-035 While reset=0 at a clock edge, the block SHALL set res_req_data, res_req_id and out_data to 0.
REQ-036 During reset, out_stall SHALL follow REQ-017 (buffers empty, so it equals global_stall).
REQ-037 A reset asserted mid-operation SHALL discard all in-flight bookkeeping; the resource is reset by the same signal.

Structure
REQ-038 Package multi_pipe_pkg SHALL hold the default parameter constants and the channel-id width function/typedef.
REQ-039 One sub-module, chan_fifo (DEPTH x DATA_W, with push/pop/flush, full/empty, wrap-around pointers), SHALL be instantiated NUM_CH times.
REQ-040 The arbiter and the counters SHALL reside in the top module.

Verification
REQ-041 Single push of 0xA5 on ch0, idle elsewhere -> res_req_valid at t+2 with id 0; response 0xA6 -> out_valid[0], out_data=0xA6 one cycle later.
REQ-042 All 4 channels push every cycle -> grants 0,1,2,3,0,...; out_stall[c] high once 4 entries are held.
REQ-043 Ch1 has 3 outstanding requests, then flush[1] -> next 3 ch1 responses dropped with no out_valid[1]; the 4th is delivered; ch2 is unaffected.
REQ-044 global_stall high for 5 cycles with res_rsp_valid asserted -> no state change and no output; activity resumes identically afterwards.
REQ-045 Response with id 3 while outstanding[3]=0 -> err_orphan=1, held until reset.
REQ-046 Reset asserted with full buffers and 8 outstanding requests -> all outputs 0 next cycle; out_stall equal to global_stall.
